// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared widths and constants for the CAM and its users.
//               CAM_MASK_ALL is the all-ones search mask (exact match).
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

   localparam int CAM_DATA_WIDTH = 16;
   localparam int CAM_ADDR_WIDTH = 4;

   localparam logic [CAM_DATA_WIDTH-1:0] CAM_MASK_ALL = '1;

endpackage
`default_nettype wire

// File: rtl/cam_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : cam_prio_enc
// Description : Combinational match-vector encoder. Produces the lowest set
//               index, a hit flag and a multi-hit flag (two or more set).
// Ports       : match_vec  in  DEPTH       one bit per CAM entry
//               hit        out 1           any bit set
//               index      out ADDR_WIDTH  lowest set index, 0 when no hit
//               multi      out 1           two or more bits set
// Revision    : 1.0 - initial release
// ============================================================================
module cam_prio_enc
   import cam_pkg::*;
#(
   parameter int DEPTH      = 1 << CAM_ADDR_WIDTH,
   parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
   input  logic [DEPTH-1:0]      match_vec,
   output logic                  hit,
   output logic [ADDR_WIDTH-1:0] index,
   output logic                  multi
);

   // Scan upward: the first set bit fixes the index; any later set bit
   // (seen while hit is already 1) flags a multi-hit.
   always_comb begin
      hit   = 1'b0;
      index = '0;
      multi = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (match_vec[i]) begin
            if (!hit) begin
               index = ADDR_WIDTH'(i);
            end
            multi = multi | hit;
            hit   = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cam_array.sv
`default_nettype none
// ============================================================================
// Module      : cam_array
// Description : Flop-based content-addressable memory with per-bit masked
//               search, lowest-index priority and multi-hit flag. Search is
//               a 2-stage pipeline (match, encode) with registered outputs.
// Ports       : clk, reset (async, active-high)
//               wr_en/wr_addr/wr_data/wr_valid  write or invalidate one entry
//               flush                           clear every valid bit
//               search_en/search_data/search_mask  issue a masked search
//               rsp_valid/cam_hit_out/cam_addr_out/multi_hit  result, 2 cycles
//               after search_en; result fields hold while rsp_valid is low
// Revision    : 1.0 - initial release
// ============================================================================
module cam_array
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = CAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   input  logic                  flush,
   input  logic                  search_en,
   input  logic [DATA_WIDTH-1:0] search_data,
   input  logic [DATA_WIDTH-1:0] search_mask,
   output logic                  rsp_valid,
   output logic                  cam_hit_out,
   output logic [ADDR_WIDTH-1:0] cam_addr_out,
   output logic                  multi_hit
);

   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

   // Storage
   logic [DATA_WIDTH-1:0] entry_q [DEPTH];
   logic [DATA_WIDTH-1:0] entry_d [DEPTH];
   logic [DEPTH-1:0]      valid_q, valid_d;

   // Stage 1 (match) and stage 2 (encode) registers
   logic [DEPTH-1:0]      match_q, match_d;
   logic                  s1_vld_q, s1_vld_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  hit_q, hit_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  multi_q, multi_d;

   logic                  w_wr_in_range;
   logic                  w_enc_hit;
   logic [ADDR_WIDTH-1:0] w_enc_index;
   logic                  w_enc_multi;

   // Out-of-range addresses are dropped (only matters when DEPTH < 2**ADDR_WIDTH).
   assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);

   // Flush is applied before the write so a simultaneous write survives.
   always_comb begin
      valid_d = valid_q;
      entry_d = entry_q;
      if (flush) begin
         valid_d = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en && w_wr_in_range && (wr_addr == ADDR_WIDTH'(i))) begin
            valid_d[i] = wr_valid;
            if (wr_valid) begin
               entry_d[i] = wr_data;
            end
         end
      end
   end

   // Match uses the pre-edge array contents, so a same-cycle write is not seen.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_d[gi] = valid_q[gi] & ~|((entry_q[gi] ^ search_data) & search_mask);
   end

   assign s1_vld_d = search_en;

   cam_prio_enc #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_prio_enc (
      .match_vec (match_q),
      .hit       (w_enc_hit),
      .index     (w_enc_index),
      .multi     (w_enc_multi)
   );

   // Result fields only move when a stage-1 search completes; otherwise hold.
   always_comb begin
      rsp_valid_d = s1_vld_q;
      hit_d       = hit_q;
      addr_d      = addr_q;
      multi_d     = multi_q;
      if (s1_vld_q) begin
         hit_d   = w_enc_hit;
         addr_d  = w_enc_index;
         multi_d = w_enc_multi;
      end
   end

   // Data array is deliberately not reset; valid bits gate every match.
   always_ff @(posedge clk) begin
      entry_q <= entry_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= '0;
         match_q     <= '0;
         s1_vld_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         hit_q       <= 1'b0;
         addr_q      <= '0;
         multi_q     <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         match_q     <= match_d;
         s1_vld_q    <= s1_vld_d;
         rsp_valid_q <= rsp_valid_d;
         hit_q       <= hit_d;
         addr_q      <= addr_d;
         multi_q     <= multi_d;
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign cam_hit_out  = hit_q;
   assign cam_addr_out = addr_q;
   assign multi_hit    = multi_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_array
// Description : Scoreboard bench for cam_array. The driver pushes the expected
//               result of every search (from an array-based reference table)
//               into a queue; the monitor pops and compares on rsp_valid.
//               DEPTH is set below 2**ADDR_WIDTH to exercise dropped writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_array;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_valid;
   logic          flush;
   logic          search_en;
   logic [DW-1:0] search_data;
   logic [DW-1:0] search_mask;
   logic          rsp_valid;
   logic          cam_hit_out;
   logic [AW-1:0] cam_addr_out;
   logic          multi_hit;

   cam_array #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .flush        (flush),
      .search_en    (search_en),
      .search_data  (search_data),
      .search_mask  (search_mask),
      .rsp_valid    (rsp_valid),
      .cam_hit_out  (cam_hit_out),
      .cam_addr_out (cam_addr_out),
      .multi_hit    (multi_hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      bit hit;
      int addr;
      bit multi;
   } exp_t;

   exp_t          sb[$];
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;
   logic [DW-1:0] m_data [DEPTH];
   bit            m_valid [DEPTH];
   bit            last_hit = 0;
   int            last_addr = 0;
   bit            last_multi = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("latency", 32'(cyc), 32'(e.due));
               chk("hit", 32'(cam_hit_out), 32'(e.hit));
               chk("addr", 32'(cam_addr_out), 32'(e.addr));
               chk("multi", 32'(multi_hit), 32'(e.multi));
               last_hit   = e.hit;
               last_addr  = e.addr;
               last_multi = e.multi;
            end
         end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               chk("missing_rsp_valid", 32'(rsp_valid), 32'd1);
               void'(sb.pop_front());
            end
            chk("hold", {29'd0, cam_hit_out, multi_hit, 1'b0} | (32'(cam_addr_out) << 4),
                {29'd0, last_hit, last_multi, 1'b0} | (32'(last_addr) << 4));
         end
      end
   end

   // One cycle of stimulus; expectation derived from the table before this edge.
   task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd, input bit wv,
                        input bit fl, input bit se, input logic [DW-1:0] sd,
                        input logic [DW-1:0] sm);
      int   hits[$];
      exp_t e;
      @(negedge clk);
      wr_en       = we;
      wr_addr     = AW'(wa);
      wr_data     = wd;
      wr_valid    = wv;
      flush       = fl;
      search_en   = se;
      search_data = sd;
      search_mask = sm;
      if (se) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && (((m_data[i] ^ sd) & sm) == '0)) hits.push_back(i);
         end
         e.due   = cyc + 2;
         e.hit   = (hits.size() > 0);
         e.addr  = (hits.size() > 0) ? hits[0] : 0;
         e.multi = (hits.size() >= 2);
         sb.push_back(e);
      end
      if (fl) begin
         for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
      end
      if (we && wa < DEPTH) begin
         m_valid[wa] = wv;
         if (wv) m_data[wa] = wd;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 0, '0, 0, 0, 0, '0, '0);
   endtask

   task automatic wr(input int wa, input logic [DW-1:0] wd, input bit wv);
      drive(1, wa, wd, wv, 0, 0, '0, '0);
   endtask

   task automatic srch(input logic [DW-1:0] sd, input logic [DW-1:0] sm);
      drive(0, 0, '0, 0, 0, 1, sd, sm);
   endtask

   // Asserts reset mid-cycle and checks outputs clear without waiting for an edge.
   task automatic reset_dut();
      @(negedge clk);
      wr_en = 0; flush = 0; search_en = 0;
      reset = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_hit", 32'(cam_hit_out), 32'd0);
      chk("rst_addr", 32'(cam_addr_out), 32'd0);
      chk("rst_multi", 32'(multi_hit), 32'd0);
      sb.delete();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
      last_hit = 0; last_addr = 0; last_multi = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] pool [4];
      int            drain;
      reset = 1'b1;
      wr_en = 0; wr_addr = '0; wr_data = '0; wr_valid = 0; flush = 0;
      search_en = 0; search_data = '0; search_mask = '0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
      repeat (3) @(negedge clk);
      chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("init_outputs", {30'd0, cam_hit_out, multi_hit} | 32'(cam_addr_out), 32'd0);
      reset = 1'b0;

      // Empty table search
      srch(16'h1234, 16'hFFFF);
      idle(2);
      // Duplicate entries, then invalidate the lower one
      wr(3, 16'hABCD, 1);
      wr(9, 16'hABCD, 1);
      srch(16'hABCD, 16'hFFFF);
      wr(3, 16'h0000, 0);
      srch(16'hABCD, 16'hFFFF);
      idle(2);
      // Same-cycle write is missed, next-cycle search sees it
      drive(1, 5, 16'h00F0, 1, 0, 1, 16'h00F0, 16'hFFFF);
      srch(16'h00F0, 16'hFFFF);
      idle(2);
      // Masked compare
      wr(2, 16'h12F4, 1);
      srch(16'h1200, 16'hFF00);
      srch(16'h1200, 16'hFFFF);
      srch(16'h0000, 16'h0000);
      idle(2);
      // Flush during back-to-back searches
      wr(7, 16'h5A5A, 1);
      srch(16'h5A5A, 16'hFFFF);
      drive(0, 0, '0, 0, 1, 1, 16'h5A5A, 16'hFFFF);
      srch(16'h5A5A, 16'hFFFF);
      srch(16'h5A5A, 16'hFFFF);
      idle(2);
      // Flush + write together, out-of-range write dropped
      wr(1, 16'h7777, 1);
      drive(1, 4, 16'h7777, 1, 1, 0, '0, '0);
      wr(13, 16'h7777, 1);
      srch(16'h7777, 16'hFFFF);
      srch(16'h0000, 16'h0000);
      idle(2);
      // Reset while a search sits in stage 1
      wr(6, 16'hBEEF, 1);
      srch(16'hBEEF, 16'hFFFF);
      reset_dut();
      srch(16'hBEEF, 16'hFFFF);
      idle(3);

      // Randomized traffic over a small key pool so hits are common
      pool[0] = 16'hABCD; pool[1] = 16'h1234; pool[2] = 16'h00F0; pool[3] = 16'hFFFF;
      for (int n = 0; n < 400; n++) begin
         logic [DW-1:0] sd, sm;
         sd = pool[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) sd = sd ^ (16'h1 << $urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       sm = 16'h0000;
            1:       sm = DW'($urandom);
            default: sm = 16'hFFFF;
         endcase
         drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
               pool[$urandom_range(0, 3)], $urandom_range(0, 4) != 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7, sd, sm);
      end
      idle(1);

      drain = 0;
      while (sb.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
